// File: rtl/text_screen_sched.sv
// Game-phase scheduler for the TicTacToe VGA text overlays.
// Runs START -> PLAY -> RESULT -> START, moving phase only on frame_tick so a
// frame never shows a torn screen. One text screen is enabled at a time, and its
// font ROM address and pixel colour are muxed onto the shared ROM and pixel path.
module text_screen_sched #(
  parameter int unsigned HOLD_FRAMES = 120,
  parameter int unsigned CNT_W       = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pixel_tick,
  input  logic        frame_tick,
  input  logic        start_btn,
  input  logic        game_over,
  input  logic [1:0]  winner,
  input  logic [10:0] start_rom_addr,
  input  logic [10:0] tie_rom_addr,
  input  logic [10:0] win_rom_addr,
  input  logic        start_text_on,
  input  logic        tie_text_on,
  input  logic        win_text_on,
  input  logic [2:0]  start_rgb,
  input  logic [2:0]  tie_rgb,
  input  logic [2:0]  win_rgb,
  output logic        start_ce,
  output logic        tie_ce,
  output logic        win_ce,
  output logic [1:0]  win_player,
  output logic [10:0] rom_addr,
  output logic        text_on,
  output logic [2:0]  text_rgb,
  output logic [1:0]  phase,
  output logic        game_enable
);

  localparam int unsigned ADDR_W = 11;
  localparam int unsigned RGB_W  = 3;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_FRAMES - 1);

  typedef enum logic [1:0] {
    PH_START  = 2'b00,
    PH_PLAY   = 2'b01,
    PH_RESULT = 2'b10
  } phase_e;

  phase_e             phase_q;
  logic               start_btn_q;
  logic               start_pend_q;
  logic               over_pend_q;
  logic [CNT_W-1:0]   hold_cnt_q;
  logic [1:0]         win_player_q;
  logic [1:0]         win_player_d;
  logic               start_ce_q;
  logic               tie_ce_q;
  logic               win_ce_q;
  logic               game_enable_q;
  logic               text_on_q;
  logic [RGB_W-1:0]   text_rgb_q;

  logic               start_rise;
  logic               start_ok;
  logic               over_ok;
  logic               sel_on;
  logic [RGB_W-1:0]   sel_rgb;
  logic [ADDR_W-1:0]  sel_addr;

  // Event qualification: button rise counts in START/RESULT, game_over only in PLAY
  assign start_rise = start_btn & ~start_btn_q;
  assign start_ok   = (phase_q == PH_START) || (phase_q == PH_RESULT);
  assign over_ok    = (phase_q == PH_PLAY);

  // Winner latch; 11 is folded to tie, a later game_over overwrites
  always_comb begin
    win_player_d = win_player_q;
    if (game_over && over_ok) begin
      win_player_d = (winner == 2'b11) ? 2'b00 : winner;
    end
  end

  // Phase FSM with pending flags, hold counter and registered enables
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q       <= PH_START;
      start_btn_q   <= 1'b0;
      start_pend_q  <= 1'b0;
      over_pend_q   <= 1'b0;
      hold_cnt_q    <= '0;
      win_player_q  <= 2'b00;
      start_ce_q    <= 1'b1;
      tie_ce_q      <= 1'b0;
      win_ce_q      <= 1'b0;
      game_enable_q <= 1'b0;
    end else begin
      start_btn_q  <= start_btn;
      win_player_q <= win_player_d;
      if (start_rise && start_ok) start_pend_q <= 1'b1;
      if (game_over && over_ok)   over_pend_q  <= 1'b1;
      if (frame_tick) begin
        case (phase_q)
          PH_START: begin
            if (start_pend_q) begin
              phase_q       <= PH_PLAY;
              start_pend_q  <= 1'b0;
              start_ce_q    <= 1'b0;
              game_enable_q <= 1'b1;
            end
          end
          PH_PLAY: begin
            if (over_pend_q) begin
              phase_q       <= PH_RESULT;
              hold_cnt_q    <= '0;
              over_pend_q   <= 1'b0;
              game_enable_q <= 1'b0;
              win_ce_q      <= (win_player_d != 2'b00);
              tie_ce_q      <= (win_player_d == 2'b00);
            end
          end
          PH_RESULT: begin
            if (start_pend_q || (hold_cnt_q == HOLD_LAST)) begin
              phase_q      <= PH_START;
              start_pend_q <= 1'b0;
              start_ce_q   <= 1'b1;
              tie_ce_q     <= 1'b0;
              win_ce_q     <= 1'b0;
            end else begin
              hold_cnt_q <= hold_cnt_q + CNT_W'(1);
            end
          end
          default: begin
            phase_q       <= PH_START;
            start_ce_q    <= 1'b1;
            tie_ce_q      <= 1'b0;
            win_ce_q      <= 1'b0;
            game_enable_q <= 1'b0;
          end
        endcase
      end
    end
  end

  // Screen select for the shared font ROM and pixel path
  always_comb begin
    sel_on   = 1'b0;
    sel_rgb  = '0;
    sel_addr = '0;
    case (phase_q)
      PH_START: begin
        sel_on   = start_text_on;
        sel_rgb  = start_rgb;
        sel_addr = start_rom_addr;
      end
      PH_RESULT: begin
        if (win_ce_q) begin
          sel_on   = win_text_on;
          sel_rgb  = win_rgb;
          sel_addr = win_rom_addr;
        end else begin
          sel_on   = tie_text_on;
          sel_rgb  = tie_rgb;
          sel_addr = tie_rom_addr;
        end
      end
      default: ;
    endcase
  end

  // Pixel path: one-clock registered overlay, advanced on pixel_tick only
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      text_on_q  <= 1'b0;
      text_rgb_q <= '0;
    end else if (pixel_tick) begin
      text_on_q  <= sel_on;
      text_rgb_q <= sel_on ? sel_rgb : '0;
    end
  end

  assign rom_addr    = sel_addr;
  assign phase       = phase_q;
  assign start_ce    = start_ce_q;
  assign tie_ce      = tie_ce_q;
  assign win_ce      = win_ce_q;
  assign win_player  = win_player_q;
  assign game_enable = game_enable_q;
  assign text_on     = text_on_q;
  assign text_rgb    = text_rgb_q;

endmodule

// File: tb/tb_text_screen_sched.sv
// Directed bench for text_screen_sched with HOLD_FRAMES=3.
module tb_text_screen_sched;

  localparam int unsigned HOLD = 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        pixel_tick, frame_tick, start_btn, game_over;
  logic [1:0]  winner;
  logic [10:0] start_rom_addr, tie_rom_addr, win_rom_addr;
  logic        start_text_on, tie_text_on, win_text_on;
  logic [2:0]  start_rgb, tie_rgb, win_rgb;
  logic        start_ce, tie_ce, win_ce;
  logic [1:0]  win_player;
  logic [10:0] rom_addr;
  logic        text_on;
  logic [2:0]  text_rgb;
  logic [1:0]  phase;
  logic        game_enable;

  int n_checks = 0;
  int n_fail   = 0;

  text_screen_sched #(.HOLD_FRAMES(HOLD), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .pixel_tick(pixel_tick), .frame_tick(frame_tick),
    .start_btn(start_btn), .game_over(game_over), .winner(winner),
    .start_rom_addr(start_rom_addr), .tie_rom_addr(tie_rom_addr), .win_rom_addr(win_rom_addr),
    .start_text_on(start_text_on), .tie_text_on(tie_text_on), .win_text_on(win_text_on),
    .start_rgb(start_rgb), .tie_rgb(tie_rgb), .win_rgb(win_rgb),
    .start_ce(start_ce), .tie_ce(tie_ce), .win_ce(win_ce), .win_player(win_player),
    .rom_addr(rom_addr), .text_on(text_on), .text_rgb(text_rgb), .phase(phase),
    .game_enable(game_enable)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its expected value
  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One frame: frame_tick high for one clock, then one idle clock
  task automatic frame();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
  endtask

  task automatic pulse_over(input logic [1:0] w);
    game_over = 1'b1;
    winner    = w;
    step();
    game_over = 1'b0;
    winner    = 2'b00;
  endtask

  task automatic press_start();
    start_btn = 1'b1;
    step();
    start_btn = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; pixel_tick = 1'b0; frame_tick = 1'b0; start_btn = 1'b0;
    game_over = 1'b0; winner = 2'b00;
    start_rom_addr = 11'h123; tie_rom_addr = 11'h2ab; win_rom_addr = 11'h3cd;
    start_text_on = 1'b0; tie_text_on = 1'b0; win_text_on = 1'b0;
    start_rgb = 3'b000; tie_rgb = 3'b000; win_rgb = 3'b000;
    step(); step();

    // Reset values
    check("rst_phase", phase, 0);
    check("rst_start_ce", start_ce, 1);
    check("rst_tie_ce", tie_ce, 0);
    check("rst_win_ce", win_ce, 0);
    check("rst_game_en", game_enable, 0);
    check("rst_win_player", win_player, 0);
    check("rst_text_on", text_on, 0);
    check("rst_text_rgb", text_rgb, 0);

    // Idle frames without start
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) frame();
    check("idle_phase", phase, 0);
    check("idle_start_ce", start_ce, 1);
    check("idle_game_en", game_enable, 0);
    check("idle_rom_addr", rom_addr, 11'h123);

    // Start rise, held high: one transition to PLAY
    start_btn = 1'b1;
    step();
    check("pre_frame_phase", phase, 0);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    check("play_phase", phase, 1);
    check("play_start_ce", start_ce, 0);
    check("play_game_en", game_enable, 1);
    check("play_rom_addr", rom_addr, 0);
    step();
    frame(); frame();
    check("play_held_phase", phase, 1);
    check("play_text_on", text_on, 0);
    start_btn = 1'b0;
    step();

    // Overlay stays blank in PLAY
    start_text_on = 1'b1; start_rgb = 3'b110; pixel_tick = 1'b1;
    step();
    pixel_tick = 1'b0;
    check("play_pix_on", text_on, 0);
    check("play_pix_rgb", text_rgb, 0);

    // O wins, then timeout after HOLD frames
    pulse_over(2'b10);
    check("go_latch", win_player, 2);
    check("go_phase_wait", phase, 1);
    frame();
    check("res_phase", phase, 2);
    check("res_win_ce", win_ce, 1);
    check("res_tie_ce", tie_ce, 0);
    check("res_win_player", win_player, 2);
    check("res_rom_addr", rom_addr, 11'h3cd);
    frame(); frame();
    check("res_hold_phase", phase, 2);
    frame();
    check("tmo_phase", phase, 0);
    check("tmo_start_ce", start_ce, 1);
    check("tmo_win_ce", win_ce, 0);

    // Winner 11 with game_over on the frame_tick cycle
    press_start();
    frame();
    check("play2_phase", phase, 1);
    frame_tick = 1'b1; game_over = 1'b1; winner = 2'b11;
    step();
    frame_tick = 1'b0; game_over = 1'b0; winner = 2'b00;
    check("same_cyc_phase", phase, 1);
    step();
    frame();
    check("tie_phase", phase, 2);
    check("tie_ce", tie_ce, 1);
    check("tie_win_ce", win_ce, 0);
    check("tie_win_player", win_player, 0);
    check("tie_rom_addr", rom_addr, 11'h2ab);

    // Early exit from RESULT at hold_cnt=1
    frame();
    press_start();
    check("early_wait_phase", phase, 2);
    frame();
    check("early_phase", phase, 0);
    check("early_start_ce", start_ce, 1);

    // game_over ignored in START
    pulse_over(2'b01);
    frame();
    check("start_go_phase", phase, 0);
    check("start_go_player", win_player, 0);

    // Enter RESULT with X, then game_over ignored in RESULT
    press_start();
    frame();
    pulse_over(2'b01);
    frame();
    check("x_phase", phase, 2);
    check("x_player", win_player, 1);
    pulse_over(2'b10);
    frame();
    check("res_go_phase", phase, 2);
    check("res_go_player", win_player, 1);

    // Win overlay pixel, then reset mid-RESULT
    win_text_on = 1'b1; win_rgb = 3'b101; pixel_tick = 1'b1;
    step();
    pixel_tick = 1'b0;
    check("win_pix_on", text_on, 1);
    check("win_pix_rgb", text_rgb, 5);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_phase", phase, 0);
    check("mid_rst_start_ce", start_ce, 1);
    check("mid_rst_win_ce", win_ce, 0);
    check("mid_rst_player", win_player, 0);
    check("mid_rst_text_on", text_on, 0);
    check("mid_rst_rgb", text_rgb, 0);
    step();
    reset_n = 1'b1;
    step();

    // Start screen pixel path latency and hold
    start_text_on = 1'b1; start_rgb = 3'b010; pixel_tick = 1'b1;
    step();
    pixel_tick = 1'b0;
    check("pix_rgb", text_rgb, 2);
    check("pix_on", text_on, 1);
    start_rgb = 3'b111;
    step(); step();
    check("pix_hold_rgb", text_rgb, 2);
    start_text_on = 1'b0; pixel_tick = 1'b1;
    step();
    pixel_tick = 1'b0;
    check("pix_off_rgb", text_rgb, 0);
    check("pix_off_on", text_on, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/text_screen_sched.md
Name: text_screen_sched

Overview:
- Game-phase scheduler for the TicTacToe VGA text overlays.
- Three text screens share one font ROM: start ("Start Playing"), tie, and win.
- The block runs the phase FSM START -> PLAY -> RESULT -> START and enables exactly one screen at a time.
- It muxes the screens' ROM addresses and colour outputs onto the single font ROM and the pixel path, and switches phase only on frame boundaries so no frame shows a torn screen.

Parameters:
HOLD_FRAMES, 120, frames the result screen is shown before returning to START (2 s at 60 Hz); legal range 1..255
CNT_W, 8, width of the frame hold counter

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
pixel_tick  in  1  pixel-rate enable
frame_tick  in  1  one-cycle pulse at start of vertical blank
start_btn  in  1  debounced start button, level
game_over  in  1  one-cycle pulse from board logic
winner  in  2  valid with game_over: 00 tie, 01 X, 10 O, 11 treated as tie
start_rom_addr, tie_rom_addr, win_rom_addr  in  11 each  font ROM address from each screen
start_text_on, tie_text_on, win_text_on  in  1 each  text-region flag from each screen
start_rgb, tie_rgb, win_rgb  in  3 each  colour from each screen
start_ce, tie_ce, win_ce  out  1 each  screen enables, one-hot or all zero
win_player  out  2  latched winner, drives the win screen text
rom_addr  out  11  font ROM address
text_on  out  1  overlay active
text_rgb  out  3  overlay colour
phase  out  2  00 START, 01 PLAY, 10 RESULT
game_enable  out  1  board/input logic enable; high only in PLAY

Behaviour:
- Reset (async, reset_n=0):
  - phase=START, start_ce=1, tie_ce=0, win_ce=0
  - game_enable=0, win_player=00, text_on=0, text_rgb=000
  - hold_cnt=0, all pending flags cleared, start_btn edge register cleared to 0
- Start edge: start_rise = start_btn & ~start_btn_q, where start_btn_q is registered every clk.
- Pending flags:
  - start_pend is set by start_rise in START or RESULT.
  - over_pend is set by game_over in PLAY only.
  - game_over outside PLAY is ignored.
  - On game_over in PLAY, winner is latched into win_player; 11 is latched as 00.
  - A second game_over before the transition overwrites win_player.
- Transitions are evaluated only on frame_tick and use the registered pending value. An event arriving in the same cycle as frame_tick takes effect at the next frame_tick.
- START: on frame_tick with start_pend -> PLAY. Clear start_pend.
- PLAY: on frame_tick with over_pend -> RESULT. hold_cnt=0, clear over_pend. start_rise is ignored.
- RESULT, evaluated on each frame_tick:
  - If start_pend: -> START, clear start_pend (early exit).
  - Else if hold_cnt==HOLD_FRAMES-1: -> START.
  - Else hold_cnt+1.
  - Early exit has priority over timeout.
- Enables are registered and change in the same cycle as phase:
  - START: start_ce=1.
  - PLAY: all ce=0, game_enable=1.
  - RESULT: win_ce=1 if win_player!=00, else tie_ce=1.
- rom_addr is combinational from the current phase: the start, tie or win address accordingly; 0 in PLAY.
- Pixel path has 1-clk latency. On clk with pixel_tick=1:
  - text_on <= selected screen's text_on.
  - text_rgb <= selected screen's rgb if its text_on=1, else 000.
  - In PLAY: text_on<=0, text_rgb<=000.
- With pixel_tick=0, text_on and text_rgb hold their values.
- A phase change mid-frame is impossible because phase only moves on frame_tick.
- A reset mid-RESULT returns to START immediately, with win_player=00.

Test Plan:
- Release reset with start_btn=0 and 5 frame_ticks -> phase stays 00, start_ce=1, game_enable=0, rom_addr==start_rom_addr.
- Raise start_btn and hold it high for 3 frames -> phase=01 exactly at the first frame_tick after the rise, with a single transition. All ce=0, game_enable=1, text_on=0, rom_addr=0.
- HOLD_FRAMES=3; in PLAY pulse game_over with winner=10 -> at next frame_tick: phase=10, win_ce=1, win_player=10. After 3 further frame_ticks: phase=00, start_ce=1.
- game_over with winner=11 in the same cycle as frame_tick -> phase stays 01 that cycle, goes 10 on the next frame_tick. tie_ce=1, win_player=00.
- In RESULT at hold_cnt=1, raise start_btn -> phase=00 at next frame_tick, not 01. game_over pulses in START and RESULT leave phase unchanged.
- In START, drive start_text_on=1, start_rgb=010 and toggle pixel_tick -> text_rgb=010 one clk after the pixel_tick cycle, held while pixel_tick=0. Assert reset_n=0 mid-RESULT -> all outputs at reset values within the same cycle.
